// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_rsp_buf.sv
// Holding register for one fetched instruction and its PC, driving the decode-side outputs.
// Latency: a load is visible on the outputs the cycle after it is captured.
// Backpressure: contents stay frozen until cleared or reloaded; outputs read 0 while not valid.
module pc_fetch_rsp_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus1_o
);

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;

  // Capture a response; a clear (dropped instruction) takes priority over a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  // Decode-side outputs are forced to 0 unless an instruction is being presented.
  always_comb begin
    valid_o    = valid_i;
    instr_o    = valid_i ? instr_q : '0;
    pc_o       = valid_i ? pc_q : '0;
    pc_plus1_o = valid_i ? (pc_q + XLEN'(1)) : '0;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one word-indexed imem request at a time, buffers the reply.
// Latency: rvalid -> if_valid 1 cycle; handshake -> next imem_req 1 cycle (3 cycles/instr at best).
// Backpressure: holds the instruction until if_ready; redirects squash in-flight fetches.
// Optional macro PC_FETCH_PERF_EN adds saturating stall/flush counters.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            rsp_load;
  logic            rsp_clear;
  logic            rsp_discard;
  logic            hold_drop;

  // State, PC and kill flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  // Next-state logic; a redirect always overrides the PC, whatever the state does.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    rsp_load    = 1'b0;
    rsp_clear   = 1'b0;
    rsp_discard = 1'b0;
    hold_drop   = 1'b0;
    unique case (state_q)
      REQ: begin
        if (imem_gnt) begin
          state_d = WAIT;
          // Old address already granted: its reply must be thrown away.
          kill_d  = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect_valid) begin
            rsp_discard = 1'b1;
            kill_d      = 1'b0;
            state_d     = REQ;
          end else begin
            rsp_load = 1'b1;
            state_d  = HOLD;
          end
        end else if (redirect_valid) begin
          // Only one request is ever outstanding, so one kill covers any number of redirects.
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          rsp_clear = 1'b1;
          hold_drop = !if_ready;
          state_d   = REQ;
        end else if (if_ready) begin
          pc_d    = pc_q + XLEN'(1);
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end
  end

  // Request side is gated by reset so nothing is driven while rst is low.
  always_comb begin
    imem_req  = rst && (state_q == REQ);
    imem_addr = rst ? pc_q : '0;
  end

  pc_fetch_rsp_buf #(
    .XLEN (XLEN)
  ) u_rsp_buf (
    .clk        (clk),
    .rst        (rst),
    .load_i     (rsp_load),
    .clear_i    (rsp_clear),
    .valid_i    (state_q == HOLD),
    .instr_i    (imem_rdata),
    .pc_i       (pc_q),
    .valid_o    (if_valid),
    .instr_o    (if_instr),
    .pc_o       (if_pc),
    .pc_plus1_o (if_pc_plus4)
  );

`ifdef PC_FETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating counters: decode stalls in HOLD, and squashed responses or dropped instructions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state_q == HOLD) && !if_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((rsp_discard || hold_drop) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed stimulus pushes expected grants/instructions,
// a negedge monitor pops and compares whenever the DUT grants a request or hands off an instruction.
// Covers reset, stalls, redirects in every state, PC wrap and mid-stream reset.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_addr_q[$];
  logic [95:0] exp_rsp_q[$];

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
`ifdef PC_FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every granted request and every accepted instruction against the queues.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (imem_req && imem_gnt) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_grant_addr", imem_addr, 32'hxxxx_xxxx);
        end else begin
          chk("grant_addr", imem_addr, exp_addr_q.pop_front());
        end
      end
      if (if_valid && if_ready) begin
        if (exp_rsp_q.size() == 0) begin
          chk("unexpected_instr", if_instr, 32'hxxxx_xxxx);
        end else begin
          logic [95:0] e;
          e = exp_rsp_q.pop_front();
          chk("if_instr", if_instr, e[95:64]);
          chk("if_pc", if_pc, e[63:32]);
          chk("if_pc_plus4", if_pc_plus4, e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req; i++) step();
    chk("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'd0);
    chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_if_instr"}, if_instr, 32'd0);
    chk({tag, "_if_pc"}, if_pc, 32'd0);
    chk({tag, "_if_pc_plus4"}, if_pc_plus4, 32'd0);
  endtask

  // Complete fetch at address a returning d, with hold_cyc stall cycles before decode accepts.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int hold_cyc);
    logic [31:0] a1;
    a1 = a + 32'd1;
    exp_addr_q.push_back(a);
    exp_rsp_q.push_back({d, a, a1});
    wait_req();
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    for (int i = 0; i < hold_cyc; i++) begin
      chk("hold_valid", {31'd0, if_valid}, 32'd1);
      chk("hold_instr", if_instr, d);
      chk("hold_pc", if_pc, a);
      chk("hold_no_req", {31'd0, imem_req}, 32'd0);
      step();
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    if_ready       = 1'b0;

    // Reset state
    repeat (3) step();
    check_reset_outs("rst0");
    rst = 1'b1;
    #1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);

    // Basic fetch, then stall 5 cycles in HOLD
    fetch(32'h0, 32'h0000_000A, 0);
    chk("next_addr_1", imem_addr, 32'h1);
    fetch(32'h1, 32'h0000_0011, 5);
`ifdef PC_FETCH_PERF_EN
    chk("perf_stall_5", perf_stall_cnt, 32'd5);
`endif

    // Redirect while waiting; reply 0xBAD must be discarded
    wait_req();
    exp_addr_q.push_back(32'h2);
    imem_gnt = 1'b1;
    step();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h0000_0BAD;
    step();
    imem_rvalid = 1'b0;
    chk("wait_redir_req", {31'd0, imem_req}, 32'd1);
    chk("wait_redir_addr", imem_addr, 32'h40);
    chk("wait_redir_novalid", {31'd0, if_valid}, 32'd0);
`ifdef PC_FETCH_PERF_EN
    chk("perf_flush_1", perf_flush_cnt, 32'd1);
`endif
    fetch(32'h40, 32'h0000_0055, 0);

    // Redirect in REQ without grant, then redirect in the same cycle as a grant
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7;
    step();
    redirect_valid = 1'b0;
    chk("req_redir_addr", imem_addr, 32'h7);
    exp_addr_q.push_back(32'h7);
    imem_gnt       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h0000_0777;
    step();
    imem_rvalid = 1'b0;
    chk("gnt_redir_addr", imem_addr, 32'h80);
    chk("gnt_redir_novalid", {31'd0, if_valid}, 32'd0);
`ifdef PC_FETCH_PERF_EN
    chk("perf_flush_2", perf_flush_cnt, 32'd2);
`endif
    fetch(32'h80, 32'h0000_0088, 1);

    // Redirect in HOLD without handshake drops the instruction
    exp_addr_q.push_back(32'h81);
    wait_req();
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_8181;
    step();
    imem_rvalid = 1'b0;
    chk("hold_drop_valid_before", {31'd0, if_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    chk("hold_drop_valid_after", {31'd0, if_valid}, 32'd0);
    chk("hold_drop_addr", imem_addr, 32'hFFFF_FFFF);
`ifdef PC_FETCH_PERF_EN
    chk("perf_flush_3", perf_flush_cnt, 32'd3);
`endif

    // PC wrap
    fetch(32'hFFFF_FFFF, 32'h0000_0099, 0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Redirect in HOLD with same-cycle handshake: accepted, redirect PC wins
    exp_addr_q.push_back(32'h0);
    exp_rsp_q.push_back({32'h0000_1234, 32'h0, 32'h1});
    wait_req();
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_1234;
    step();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    if_ready       = 1'b1;
    step();
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    chk("hs_redir_addr", imem_addr, 32'h20);
    chk("hs_redir_novalid", {31'd0, if_valid}, 32'd0);

    // Redirect with rvalid in WAIT: reply discarded, no pending kill
    exp_addr_q.push_back(32'h20);
    wait_req();
    imem_gnt = 1'b1;
    step();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h0000_DEAD;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h30;
    step();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    chk("rv_redir_req", {31'd0, imem_req}, 32'd1);
    chk("rv_redir_addr", imem_addr, 32'h30);
    fetch(32'h30, 32'h0000_3030, 0);

    // Reset asserted while holding an instruction
    exp_addr_q.push_back(32'h31);
    wait_req();
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_3131;
    step();
    imem_rvalid = 1'b0;
    chk("mid_hold_instr", if_instr, 32'h0000_3131);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    fetch(32'h0, 32'h0000_F00D, 0);

    step();
    chk("addr_queue_empty", exp_addr_q.size(), 32'd0);
    chk("rsp_queue_empty", exp_rsp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch sequencer that owns the program counter and sequences instruction-memory requests. It issues one word-indexed fetch at a time over a req/gnt + rvalid interface and buffers the response. It presents the instruction to decode with a valid/ready handshake, and it applies branch/jump redirects from execute, squashing any in-flight fetch.

Parameters:
XLEN, 32, width of PC, addresses and instruction word
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (asserted at 0)
redirect_valid  input  1  execute requests PC redirect this cycle
redirect_pc  input  XLEN  redirect target (word index)
imem_req  output  1  fetch request
imem_addr  output  XLEN  fetch address (= current pc)
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid (exactly one per granted request, >=1 cycle after gnt)
imem_rdata  input  XLEN  response instruction
if_valid  output  1  instruction to decode valid
if_ready  input  1  decode accepts instruction
if_instr  output  XLEN  buffered instruction
if_pc  output  XLEN  PC of if_instr
if_pc_plus4  output  XLEN  if_pc + 1 (word indexing; name kept for datapath consistency)

Behaviour:
- States: REQ, WAIT, HOLD. Registers: pc, state, kill, instr_q, pc_q.
- Reset (rst=0, async): pc=RESET_PC, state=REQ, kill=0, instr_q=0, pc_q=0. All outputs 0 while in reset, including imem_req, if_valid and all data outputs.
- REQ: imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> WAIT.
  - imem_addr changes while ungranted only on redirect.
- WAIT: imem_req=0.
  - On imem_rvalid with kill=0: instr_q=imem_rdata, pc_q=pc -> HOLD.
  - On imem_rvalid with kill=1: response discarded, kill=0 -> REQ.
- HOLD: if_valid=1, if_instr=instr_q, if_pc=pc_q, if_pc_plus4=pc_q+1.
  - if_valid, if_instr and if_pc stay stable until the handshake.
  - On if_valid&&if_ready: pc=pc+1 -> REQ.
- Latency:
  - rvalid -> if_valid: 1 cycle.
  - Handshake -> next imem_req: 1 cycle.
  - Zero-wait memory gives 1 instruction per 3 cycles. Throughput is not a goal.
- Redirect (highest priority, any state), pc=redirect_pc and:
  - REQ, no gnt: stay REQ; new address visible next cycle.
  - REQ with gnt same cycle: old-address request already granted, so kill=1 -> WAIT.
  - WAIT without rvalid: kill=1.
  - WAIT with rvalid same cycle: response discarded, kill stays 0 -> REQ.
  - HOLD: buffered instr dropped, if_valid=0 next cycle -> REQ. A same-cycle if_ready handshake still counts as accepted; redirect pc wins over pc+1.
  - Repeated redirects while kill=1: pc takes the latest target; exactly one response is discarded.
- Arithmetic: pc+1 modulo 2^XLEN; 0xFFFF_FFFF wraps to 0.
- Reset asserted mid-transaction: everything returns to reset values immediately. Memory responses arriving after reset release with no new grant are a protocol error and need not be handled.

Optional Feature:
PC_FETCH_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0 and saturating at 0xFFFF_FFFF.
  - perf_stall_cnt: cycles in HOLD with if_ready=0.
  - perf_flush_cnt: discarded responses plus HOLD drops.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package pc_fetch_pkg: state enum fetch_state_e {REQ, WAIT, HOLD}; XLEN default; RESET_PC default.
- One sub-module pc_fetch_rsp_buf: instr_q/pc_q holding register with load and clear, driving if_* outputs.
- FSM, pc register and redirect/kill logic stay in the top.

Test Plan:
- Reset release, RESET_PC=0, gnt same cycle, rvalid 1 cycle later with 0xA, if_ready=1 -> if_valid with if_pc=0, if_pc_plus4=1; next imem_addr=1.
- if_ready held 0 for 5 cycles in HOLD -> if_instr and if_pc stable, no imem_req; with PERF, perf_stall_cnt=5.
- Redirect to 0x40 in WAIT, then rvalid with 0xBAD -> 0xBAD never presented; next imem_addr=0x40; perf_flush_cnt=1.
- Redirect to 0x80 in the same cycle as gnt at pc=7 -> response for 7 discarded; next request at 0x80.
- pc=0xFFFF_FFFF, fetch completes and handshakes -> next imem_addr=0.
- rst=0 asserted in HOLD mid-stream -> if_valid and imem_req drop immediately; after release, imem_addr=RESET_PC.
